fft_butterfly_radix2: RTL and testbench



---
 rtl/fft_pkg.sv | 27 ++
 rtl/fixed_point_multiplier.sv | 61 ++++++
 rtl/fft_butterfly_radix2.sv | 154 +++++++++++++++
 tb/tb_fft_butterfly_radix2.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_pkg                                                              |
// | Shared widths, saturation limits and butterfly FSM states.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fft_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_EXP_WIDTH  = 15;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_RR  = 3'd1,
    MUL_II  = 3'd2,
    MUL_RI  = 3'd3,
    MUL_IR  = 3'd4,
    COMBINE = 3'd5,
    HOLD    = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fixed_point_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fixed_point_multiplier                                               |
// | Signed fixed-point multiply, floor truncation, saturating output,    |
// | one-cycle done pulse per enabled operation.                          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fixed_point_multiplier #(
  parameter int WIDTH_A           = 16,
  parameter int WIDTH_B           = 16,
  parameter int WIDTH_PRODUCT     = 16,
  parameter int EXP_WIDTH_A       = 15,
  parameter int EXP_WIDTH_B       = 15,
  parameter int EXP_WIDTH_PRODUCT = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic signed [WIDTH_A-1:0]       a,
  input  logic signed [WIDTH_B-1:0]       b,
  output logic signed [WIDTH_PRODUCT-1:0] product,
  output logic                            done
);

  localparam int c_fw    = WIDTH_A + WIDTH_B;
  localparam int c_shift = EXP_WIDTH_A + EXP_WIDTH_B - EXP_WIDTH_PRODUCT;
  localparam logic signed [c_fw-1:0] c_max = (c_fw'(1) <<< (WIDTH_PRODUCT - 1)) - c_fw'(1);
  localparam logic signed [c_fw-1:0] c_min = ~c_max;

  logic signed [c_fw-1:0]          w_full;
  logic signed [c_fw-1:0]          w_shift;
  logic signed [WIDTH_PRODUCT-1:0] w_sat;
  logic signed [WIDTH_PRODUCT-1:0] r_product;
  logic                            r_done;

  assign w_full  = c_fw'(a) * c_fw'(b);
  assign w_shift = w_full >>> c_shift;
  assign w_sat   = (w_shift > c_max) ? c_max[WIDTH_PRODUCT-1:0] :
                   (w_shift < c_min) ? c_min[WIDTH_PRODUCT-1:0] :
                                       w_shift[WIDTH_PRODUCT-1:0];

  // The cycle after done is a dead cycle so a held enable cannot re-fire
  // on operands the consumer has not yet switched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product <= '0;
      r_done    <= 1'b0;
    end else if (en && !r_done) begin
      r_product <= w_sat;
      r_done    <= 1'b1;
    end else begin
      r_done    <= 1'b0;
    end
  end

  assign product = r_product;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: rtl/fft_butterfly_radix2.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_butterfly_radix2                                                 |
// | Radix-2 DIT butterfly, T = B*W via one shared multiplier.            |
// | Optional macro FFT_BUTTERFLY_SCALE_EN: halve each output (floor).    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fft_butterfly_radix2
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int EXP_WIDTH  = DEF_EXP_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] a_re,
  input  logic signed [DATA_WIDTH-1:0] a_im,
  input  logic signed [DATA_WIDTH-1:0] b_re,
  input  logic signed [DATA_WIDTH-1:0] b_im,
  input  logic signed [DATA_WIDTH-1:0] w_re,
  input  logic signed [DATA_WIDTH-1:0] w_im,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] x0_re,
  output logic signed [DATA_WIDTH-1:0] x0_im,
  output logic signed [DATA_WIDTH-1:0] x1_re,
  output logic signed [DATA_WIDTH-1:0] x1_im
);

  localparam int c_msb = DATA_WIDTH - 1;
  localparam int c_tw  = DATA_WIDTH + 1;
  localparam int c_sw  = DATA_WIDTH + 2;

  state_t r_state, w_state_next;

  logic signed [DATA_WIDTH-1:0] r_a_re, r_a_im, r_b_re, r_b_im, r_w_re, r_w_im;
  logic signed [DATA_WIDTH-1:0] r_pr_rr, r_pr_ii, r_pr_ri, r_pr_ir;
  logic signed [DATA_WIDTH-1:0] r_x0_re, r_x0_im, r_x1_re, r_x1_im;

  logic                         w_mul_en;
  logic                         w_mul_done;
  logic signed [DATA_WIDTH-1:0] w_mul_a, w_mul_b, w_mul_p;

  logic signed [c_tw-1:0] w_t_re, w_t_im;
  logic signed [c_sw-1:0] w_s0_re, w_s0_im, w_s1_re, w_s1_im;

  function automatic logic signed [c_sw-1:0] scale(input logic signed [c_sw-1:0] v);
`ifdef FFT_BUTTERFLY_SCALE_EN
    return v >>> 1;
`else
    return v;
`endif
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [c_sw-1:0] v);
    if (v > c_sw'(SAT_MAX))      return DATA_WIDTH'(SAT_MAX);
    else if (v < c_sw'(SAT_MIN)) return DATA_WIDTH'(SAT_MIN);
    else                         return v[DATA_WIDTH-1:0];
  endfunction

  fixed_point_multiplier #(
    .WIDTH_A          (DATA_WIDTH),
    .WIDTH_B          (DATA_WIDTH),
    .WIDTH_PRODUCT    (DATA_WIDTH),
    .EXP_WIDTH_A      (EXP_WIDTH),
    .EXP_WIDTH_B      (EXP_WIDTH),
    .EXP_WIDTH_PRODUCT(EXP_WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_mul_en),
    .a      (w_mul_a),
    .b      (w_mul_b),
    .product(w_mul_p),
    .done   (w_mul_done)
  );

  assign w_t_re  = $signed({r_pr_rr[c_msb], r_pr_rr}) - $signed({r_pr_ii[c_msb], r_pr_ii});
  assign w_t_im  = $signed({r_pr_ri[c_msb], r_pr_ri}) + $signed({r_pr_ir[c_msb], r_pr_ir});
  assign w_s0_re = $signed({{2{r_a_re[c_msb]}}, r_a_re}) + $signed({w_t_re[c_tw-1], w_t_re});
  assign w_s0_im = $signed({{2{r_a_im[c_msb]}}, r_a_im}) + $signed({w_t_im[c_tw-1], w_t_im});
  assign w_s1_re = $signed({{2{r_a_re[c_msb]}}, r_a_re}) - $signed({w_t_re[c_tw-1], w_t_re});
  assign w_s1_im = $signed({{2{r_a_im[c_msb]}}, r_a_im}) - $signed({w_t_im[c_tw-1], w_t_im});

  always_comb begin
    w_state_next = r_state;
    w_mul_en     = 1'b0;
    w_mul_a      = '0;
    w_mul_b      = '0;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = MUL_RR;
      MUL_RR: begin
        w_mul_en = 1'b1; w_mul_a = r_b_re; w_mul_b = r_w_re;
        if (w_mul_done) w_state_next = MUL_II;
      end
      MUL_II: begin
        w_mul_en = 1'b1; w_mul_a = r_b_im; w_mul_b = r_w_im;
        if (w_mul_done) w_state_next = MUL_RI;
      end
      MUL_RI: begin
        w_mul_en = 1'b1; w_mul_a = r_b_re; w_mul_b = r_w_im;
        if (w_mul_done) w_state_next = MUL_IR;
      end
      MUL_IR: begin
        w_mul_en = 1'b1; w_mul_a = r_b_im; w_mul_b = r_w_re;
        if (w_mul_done) w_state_next = COMBINE;
      end
      COMBINE: w_state_next = HOLD;
      HOLD:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_re  <= '0; r_a_im  <= '0; r_b_re  <= '0;
      r_b_im  <= '0; r_w_re  <= '0; r_w_im  <= '0;
      r_pr_rr <= '0; r_pr_ii <= '0; r_pr_ri <= '0; r_pr_ir <= '0;
      r_x0_re <= '0; r_x0_im <= '0; r_x1_re <= '0; r_x1_im <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: if (in_valid) begin
          r_a_re <= a_re; r_a_im <= a_im; r_b_re <= b_re;
          r_b_im <= b_im; r_w_re <= w_re; r_w_im <= w_im;
        end
        MUL_RR: if (w_mul_done) r_pr_rr <= w_mul_p;
        MUL_II: if (w_mul_done) r_pr_ii <= w_mul_p;
        MUL_RI: if (w_mul_done) r_pr_ri <= w_mul_p;
        MUL_IR: if (w_mul_done) r_pr_ir <= w_mul_p;
        COMBINE: begin
          r_x0_re <= sat(scale(w_s0_re));
          r_x0_im <= sat(scale(w_s0_im));
          r_x1_re <= sat(scale(w_s1_re));
          r_x1_im <= sat(scale(w_s1_im));
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == HOLD);
  assign x0_re     = r_x0_re;
  assign x0_im     = r_x0_im;
  assign x1_re     = r_x1_re;
  assign x1_im     = r_x1_im;

endmodule
`default_nettype wire

// File: tb/tb_fft_butterfly_radix2.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fft_butterfly_radix2                                              |
// | Scoreboard bench: directed vectors, backpressure, reset, random.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fft_butterfly_radix2;
  import fft_pkg::*;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [DW-1:0] x0_re, x0_im, x1_re, x1_im;

  typedef struct { int x0r; int x0i; int x1r; int x1i; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  bit rand_bp = 1'b0;
  bit fixed_ready = 1'b1;

  fft_butterfly_radix2 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im)
  );

  always #5 clk = ~clk;

  function automatic int sat(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Real-valued product of two Q1.15 numbers, floored to the Q1.15 grid.
  function automatic int qmul(int a, int b);
    real r;
    r = $floor((real'(a) / 32768.0) * (real'(b) / 32768.0) * 32768.0);
    return sat(int'(r));
  endfunction

  function automatic int stage_scale(int s);
`ifdef FFT_BUTTERFLY_SCALE_EN
    return int'($floor(real'(s) / 2.0));
`else
    return s;
`endif
  endfunction

  function automatic exp_t model(int ar, int ai, int br, int bi, int wr, int wi);
    exp_t e;
    int tr, ti;
    tr = qmul(br, wr) - qmul(bi, wi);
    ti = qmul(br, wi) + qmul(bi, wr);
    e.x0r = sat(stage_scale(ar + tr));
    e.x0i = sat(stage_scale(ai + ti));
    e.x1r = sat(stage_scale(ar - tr));
    e.x1i = sat(stage_scale(ai - ti));
    return e;
  endfunction

  function automatic exp_t mk(int p, int q, int r, int s);
    exp_t e;
    e.x0r = p; e.x0i = q; e.x1r = r; e.x1i = s;
    return e;
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int rnd16();
    case ($urandom_range(0, 7))
      0: return 32767;
      1: return -32768;
      2: return 0;
      default: return int'($signed(16'($urandom())));
    endcase
  endfunction

  // Monitor: pops expected results on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) check("in_ready_during_hold", int'(in_ready), 0);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got x0_re=%0d, required no output", x0_re);
        end else begin
          e = sb.pop_front();
          check("x0_re", x0_re, e.x0r);
          check("x0_im", x0_im, e.x0i);
          check("x1_re", x1_re, e.x1r);
          check("x1_im", x1_im, e.x1i);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end
  end

  // Presents an operand set and holds in_valid until the DUT will take it on
  // the next rising edge; the caller's next posedge wait is that edge.
  task automatic send(int ar, int ai, int br, int bi, int wr, int wi, exp_t e);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    a_re = DW'(ar); a_im = DW'(ai); b_re = DW'(br);
    b_im = DW'(bi); w_re = DW'(wr); w_im = DW'(wi);
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0, required 1 within 300 cycles");
    end
  endtask

  task automatic send_m(int ar, int ai, int br, int bi, int wr, int wi);
    send(ar, ai, br, bi, wr, wi, model(ar, ai, br, bi, wr, wi));
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    int hx0r, hx0i, hx1r, hx1i;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_x0_re", x0_re, 0);
    check("reset_x1_im", x1_im, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);

    // Directed vectors with hand-derived results
`ifdef FFT_BUTTERFLY_SCALE_EN
    send(16384, 0, 8192, 0, 32767, 0, mk(12287, 0, 4096, 0));
    send(0, 0, 8192, 0, 0, -32768, mk(0, -4096, 0, 4096));
    send(32767, 0, 32767, 0, 32767, 0, mk(32766, 0, 0, 0));
`else
    send(16384, 0, 8192, 0, 32767, 0, mk(24575, 0, 8193, 0));
    send(0, 0, 8192, 0, 0, -32768, mk(0, -8192, 0, 8192));
    send(32767, 0, 32767, 0, 32767, 0, mk(32767, 0, 1, 0));
`endif
    idle_in();
    drain();

    // Backpressure: outputs held, in_ready low, stray in_valid ignored
    fixed_ready = 1'b0;
    @(posedge clk);
    send_m(12000, -7000, 20000, 3000, 23170, -23170);
    idle_in();
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check("bp_out_valid_seen", int'(seen), 1);
    hx0r = x0_re; hx0i = x0_im; hx1r = x1_re; hx1i = x1_im;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid = k[0];
      a_re = DW'(rnd16()); b_re = DW'(rnd16()); w_re = DW'(rnd16());
      @(negedge clk);
      check("bp_out_valid_held", int'(out_valid), 1);
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_x0_re_stable", x0_re, hx0r);
      check("bp_x0_im_stable", x0_im, hx0i);
      check("bp_x1_re_stable", x1_re, hx1r);
      check("bp_x1_im_stable", x1_im, hx1i);
    end
    in_valid = 1'b0;
    fixed_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_out_valid", int'(out_valid), 0);
    check("bp_release_in_ready", int'(in_ready), 1);
    drain();

    // Reset in the middle of a multiply sequence
    send_m(1000, 2000, 3000, 4000, 5000, 6000);
    idle_in();
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dut.r_state == MUL_RI) begin seen = 1'b1; break; end
    end
    check("midop_reached_mul_ri", int'(seen), 1);
    rst_n = 1'b0;
    #1;
    check("midop_out_valid", int'(out_valid), 0);
    check("midop_x0_re", x0_re, 0);
    check("midop_x0_im", x0_im, 0);
    check("midop_x1_re", x1_re, 0);
    check("midop_x1_im", x1_im, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midop_in_ready_after", int'(in_ready), 1);
`ifdef FFT_BUTTERFLY_SCALE_EN
    send(16384, 0, 8192, 0, 32767, 0, mk(12287, 0, 4096, 0));
`else
    send(16384, 0, 8192, 0, 32767, 0, mk(24575, 0, 8193, 0));
`endif
    idle_in();
    drain();

    // Back-to-back with in_valid held high
    send_m(-16000, 9000, 32767, -32768, -32768, 32767);
    send_m(5, -5, -32768, -32768, -32768, -32768);
    send_m(30000, 30000, 30000, 30000, 30000, -30000);
    idle_in();
    drain();

    // Randomized traffic with random backpressure and idle gaps
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send_m(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
      if ($urandom_range(0, 2) == 0) begin
        idle_in();
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
    end
    idle_in();
    drain();
    rand_bp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
